// File: rtl/fcs_check_parallel.sv
// Ethernet FCS (CRC-32) receive checker, 1/2/4/8 bits per word, with runt and abort detection.
// Verdict registered one cycle after the last FCS word; data_valid low is a pure stall, no backpressure.
module fcs_check_parallel #(
  parameter int DATA_WIDTH      = 8,
  parameter int MIN_FRAME_BYTES = 60,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   data_valid,
  input  logic                   start_of_frame,
  input  logic                   end_of_frame,
  input  logic [DATA_WIDTH-1:0]  data_in,
  output logic                   result_valid,
  output logic                   fcs_error,
  output logic                   runt_error,
  output logic                   frame_aborted,
  output logic [COUNT_WIDTH-1:0] error_count
);

  localparam logic [31:0] POLY      = 32'h04C11DB7;
  localparam int          FCS_WORDS = 32 / DATA_WIDTH;
  localparam int          MIN_WORDS = MIN_FRAME_BYTES * 8 / DATA_WIDTH;
  localparam int          LEN_W     = (MIN_WORDS > 0) ? $clog2(MIN_WORDS + 1) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MIN_WORDS);
  localparam logic [5:0]       FCS_LAST = 6'(FCS_WORDS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_FCS  = 2'd2;

  if (DATA_WIDTH != 1 && DATA_WIDTH != 2 && DATA_WIDTH != 4 && DATA_WIDTH != 8) begin : g_bad_width
    $error("fcs_check_parallel: DATA_WIDTH must be 1, 2, 4 or 8");
  end

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [DATA_WIDTH-1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? POLY : 32'd0);
    end
    return r;
  endfunction

  logic [1:0]       state_q;
  logic [31:0]      crc_q;
  logic [LEN_W-1:0] len_q;
  logic [5:0]       fcnt_q;
  logic             runt_q;

  logic             new_frame;
  logic             abort;
  logic             enter_fcs;
  logic             fcs_word;
  logic             finish;
  logic [31:0]      crc_next;
  logic             crc_bad;
  logic [LEN_W-1:0] len_base;
  logic [LEN_W-1:0] len_next;
  logic             runt_next;

  always_comb begin
    new_frame = data_valid && start_of_frame;
    abort     = new_frame && (state_q != ST_IDLE);
    enter_fcs = data_valid && end_of_frame && (new_frame || state_q == ST_DATA);
    // The end_of_frame word and everything after it in FCS are complemented before the CRC.
    fcs_word  = enter_fcs || (state_q == ST_FCS && !new_frame);
    finish    = data_valid && !new_frame && (state_q == ST_FCS) && (fcnt_q == FCS_LAST);
    crc_next  = crc_step(new_frame ? 32'hFFFF_FFFF : crc_q, fcs_word ? ~data_in : data_in);
    crc_bad   = |crc_next;
    len_base  = new_frame ? '0 : len_q;
    len_next  = (len_base < LEN_MAX) ? len_base + LEN_W'(1) : len_base;
    runt_next = len_base < LEN_MAX;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      crc_q   <= 32'd0;
      len_q   <= '0;
      fcnt_q  <= 6'd0;
      runt_q  <= 1'b0;
    end else if (data_valid) begin
      if (new_frame) begin
        crc_q <= crc_next;
        if (end_of_frame) begin
          state_q <= ST_FCS;
          fcnt_q  <= 6'd1;
          runt_q  <= runt_next;
        end else begin
          state_q <= ST_DATA;
          len_q   <= len_next;
        end
      end else begin
        case (state_q)
          ST_DATA: begin
            crc_q <= crc_next;
            if (end_of_frame) begin
              state_q <= ST_FCS;
              fcnt_q  <= 6'd1;
              runt_q  <= runt_next;
            end else begin
              len_q <= len_next;
            end
          end
          ST_FCS: begin
            crc_q <= crc_next;
            if (finish) state_q <= ST_IDLE;
            else        fcnt_q  <= fcnt_q + 6'd1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_valid  <= 1'b0;
      fcs_error     <= 1'b0;
      runt_error    <= 1'b0;
      frame_aborted <= 1'b0;
      error_count   <= '0;
    end else begin
      result_valid <= finish || abort;
      if (finish) begin
        fcs_error     <= crc_bad;
        runt_error    <= runt_q;
        frame_aborted <= 1'b0;
      end else if (abort) begin
        fcs_error     <= 1'b0;
        runt_error    <= 1'b0;
        frame_aborted <= 1'b1;
      end
      if (((finish && (crc_bad || runt_q)) || abort) && !(&error_count)) begin
        error_count <= error_count + COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fcs_check_parallel.sv
// Directed bench for fcs_check_parallel across data widths, runt length, count saturation and reset.
module tb_fcs_check_parallel;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  // Instances: 0=w8 min0, 1=w4 min0, 2=w2 min0, 3=w1 min0, 4=defaults, 5=w8 min0 count2
  logic        dv  [6];
  logic        sof [6];
  logic        eof [6];
  logic [7:0]  din [6];
  logic        rv  [6];
  logic        fe  [6];
  logic        re  [6];
  logic        fa  [6];
  logic [15:0] ec  [6];
  logic [1:0]  ec5;
  assign ec[5] = {14'd0, ec5};

  int wid [6] = '{8, 4, 2, 1, 8, 8};
  int pulses [6] = '{0, 0, 0, 0, 0, 0};
  int aborts [6] = '{0, 0, 0, 0, 0, 0};
  int total = 0;
  int bad = 0;

  fcs_check_parallel #(.DATA_WIDTH(8), .MIN_FRAME_BYTES(0), .COUNT_WIDTH(16)) u_w8 (
    .clk(clk), .reset_n(reset_n), .data_valid(dv[0]), .start_of_frame(sof[0]),
    .end_of_frame(eof[0]), .data_in(din[0]), .result_valid(rv[0]), .fcs_error(fe[0]),
    .runt_error(re[0]), .frame_aborted(fa[0]), .error_count(ec[0]));
  fcs_check_parallel #(.DATA_WIDTH(4), .MIN_FRAME_BYTES(0), .COUNT_WIDTH(16)) u_w4 (
    .clk(clk), .reset_n(reset_n), .data_valid(dv[1]), .start_of_frame(sof[1]),
    .end_of_frame(eof[1]), .data_in(din[1][3:0]), .result_valid(rv[1]), .fcs_error(fe[1]),
    .runt_error(re[1]), .frame_aborted(fa[1]), .error_count(ec[1]));
  fcs_check_parallel #(.DATA_WIDTH(2), .MIN_FRAME_BYTES(0), .COUNT_WIDTH(16)) u_w2 (
    .clk(clk), .reset_n(reset_n), .data_valid(dv[2]), .start_of_frame(sof[2]),
    .end_of_frame(eof[2]), .data_in(din[2][1:0]), .result_valid(rv[2]), .fcs_error(fe[2]),
    .runt_error(re[2]), .frame_aborted(fa[2]), .error_count(ec[2]));
  fcs_check_parallel #(.DATA_WIDTH(1), .MIN_FRAME_BYTES(0), .COUNT_WIDTH(16)) u_w1 (
    .clk(clk), .reset_n(reset_n), .data_valid(dv[3]), .start_of_frame(sof[3]),
    .end_of_frame(eof[3]), .data_in(din[3][0:0]), .result_valid(rv[3]), .fcs_error(fe[3]),
    .runt_error(re[3]), .frame_aborted(fa[3]), .error_count(ec[3]));
  fcs_check_parallel u_def (
    .clk(clk), .reset_n(reset_n), .data_valid(dv[4]), .start_of_frame(sof[4]),
    .end_of_frame(eof[4]), .data_in(din[4]), .result_valid(rv[4]), .fcs_error(fe[4]),
    .runt_error(re[4]), .frame_aborted(fa[4]), .error_count(ec[4]));
  fcs_check_parallel #(.DATA_WIDTH(8), .MIN_FRAME_BYTES(0), .COUNT_WIDTH(2)) u_sat (
    .clk(clk), .reset_n(reset_n), .data_valid(dv[5]), .start_of_frame(sof[5]),
    .end_of_frame(eof[5]), .data_in(din[5]), .result_valid(rv[5]), .fcs_error(fe[5]),
    .runt_error(re[5]), .frame_aborted(fa[5]), .error_count(ec5));

  always @(negedge clk) begin
    for (int k = 0; k < 6; k++) begin
      if (rv[k] === 1'b1) begin
        pulses[k] = pulses[k] + 1;
        if (fa[k] === 1'b1) aborts[k] = aborts[k] + 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference CRC in the reflected (LSB-first) form; FCS goes out low byte first.
  function automatic bq_t make_frame(input bq_t p);
    logic [31:0] c;
    bq_t f;
    c = 32'hFFFF_FFFF;
    f = p;
    foreach (p[i]) begin
      c = c ^ {24'd0, p[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    c = ~c;
    f.push_back(c[7:0]);
    f.push_back(c[15:8]);
    f.push_back(c[23:16]);
    f.push_back(c[31:24]);
    return f;
  endfunction

  function automatic bq_t check_frame();
    bq_t f;
    f = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
          8'h26, 8'h39, 8'hF4, 8'hCB};
    return f;
  endfunction

  task automatic send_frame(input int k, input bq_t d, input bit with_sof, input bit has_fcs,
                            input int stall);
    int w;
    int n;
    logic [7:0] tmp;
    w = wid[k];
    n = 8 / w;
    for (int i = 0; i < d.size(); i++) begin
      for (int j = 0; j < n; j++) begin
        while (stall > 0 && $urandom_range(99) < stall) begin
          @(posedge clk); #1;
        end
        if (stall > 0 && has_fcs && i == d.size() - 3 && j == 0) begin
          @(posedge clk); #1;
        end
        tmp = d[i] >> (j * w);
        dv[k]  = 1'b1;
        sof[k] = with_sof && (i == 0) && (j == 0);
        eof[k] = has_fcs && (i == d.size() - 4) && (j == 0);
        din[k] = tmp & 8'((1 << w) - 1);
        @(posedge clk); #1;
        dv[k]  = 1'b0;
        sof[k] = 1'b0;
        eof[k] = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) begin
      total++; if (rv[k] !== 1'b0) begin bad++; $display("FAIL reset_rv[%0d] got=%b want=0", k, rv[k]); end
      total++; if (fe[k] !== 1'b0) begin bad++; $display("FAIL reset_fe[%0d] got=%b want=0", k, fe[k]); end
      total++; if (re[k] !== 1'b0) begin bad++; $display("FAIL reset_re[%0d] got=%b want=0", k, re[k]); end
      total++; if (fa[k] !== 1'b0) begin bad++; $display("FAIL reset_fa[%0d] got=%b want=0", k, fa[k]); end
      total++; if (ec[k] !== 16'd0) begin bad++; $display("FAIL reset_ec[%0d] got=%0d want=0", k, ec[k]); end
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_check_value();
    int p;
    p = pulses[0];
    send_frame(0, check_frame(), 1'b1, 1'b1, 0);
    total++; if (rv[0] !== 1'b1) begin bad++; $display("FAIL chk_rv got=%b want=1", rv[0]); end
    total++; if (fe[0] !== 1'b0) begin bad++; $display("FAIL chk_fe got=%b want=0", fe[0]); end
    total++; if (re[0] !== 1'b0) begin bad++; $display("FAIL chk_re got=%b want=0", re[0]); end
    total++; if (ec[0] !== 16'd0) begin bad++; $display("FAIL chk_ec got=%0d want=0", ec[0]); end
    @(posedge clk); #1;
    total++; if (rv[0] !== 1'b0) begin bad++; $display("FAIL chk_rv_pulse got=%b want=0", rv[0]); end
    total++; if (pulses[0] - p !== 1) begin bad++; $display("FAIL chk_pulses got=%0d want=1", pulses[0] - p); end
  endtask

  task automatic test_corrupt();
    bq_t f;
    f = check_frame();
    f[4] = 8'h3D;
    for (int k = 0; k < 4; k++) begin
      send_frame(k, f, 1'b1, 1'b1, 0);
      total++; if (rv[k] !== 1'b1) begin bad++; $display("FAIL bad_rv[w%0d] got=%b want=1", wid[k], rv[k]); end
      total++; if (fe[k] !== 1'b1) begin bad++; $display("FAIL bad_fe[w%0d] got=%b want=1", wid[k], fe[k]); end
      total++; if (re[k] !== 1'b0) begin bad++; $display("FAIL bad_re[w%0d] got=%b want=0", wid[k], re[k]); end
      total++; if (ec[k] !== 16'd1) begin bad++; $display("FAIL bad_ec[w%0d] got=%0d want=1", wid[k], ec[k]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_runt();
    bq_t p;
    p = {};
    for (int i = 0; i < 59; i++) p.push_back(8'(i * 7 + 3));
    send_frame(4, make_frame(p), 1'b1, 1'b1, 0);
    total++; if (re[4] !== 1'b1) begin bad++; $display("FAIL runt59_re got=%b want=1", re[4]); end
    total++; if (fe[4] !== 1'b0) begin bad++; $display("FAIL runt59_fe got=%b want=0", fe[4]); end
    total++; if (ec[4] !== 16'd1) begin bad++; $display("FAIL runt59_ec got=%0d want=1", ec[4]); end
    @(posedge clk); #1;
    p.push_back(8'hA5);
    send_frame(4, make_frame(p), 1'b1, 1'b1, 0);
    total++; if (re[4] !== 1'b0) begin bad++; $display("FAIL len60_re got=%b want=0", re[4]); end
    total++; if (fe[4] !== 1'b0) begin bad++; $display("FAIL len60_fe got=%b want=0", fe[4]); end
    total++; if (ec[4] !== 16'd1) begin bad++; $display("FAIL len60_ec got=%0d want=1", ec[4]); end
    @(posedge clk); #1;
    // Empty frame: start and end of frame on the same word, FCS of nothing is 00000000.
    p = {};
    send_frame(4, make_frame(p), 1'b1, 1'b1, 0);
    total++; if (re[4] !== 1'b1) begin bad++; $display("FAIL empty_re got=%b want=1", re[4]); end
    total++; if (fe[4] !== 1'b0) begin bad++; $display("FAIL empty_fe got=%b want=0", fe[4]); end
    total++; if (ec[4] !== 16'd2) begin bad++; $display("FAIL empty_ec got=%0d want=2", ec[4]); end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    int p;
    p = pulses[0];
    send_frame(0, check_frame(), 1'b1, 1'b1, 50);
    total++; if (rv[0] !== 1'b1) begin bad++; $display("FAIL stall_rv got=%b want=1", rv[0]); end
    total++; if (fe[0] !== 1'b0) begin bad++; $display("FAIL stall_fe got=%b want=0", fe[0]); end
    total++; if (ec[0] !== 16'd1) begin bad++; $display("FAIL stall_ec got=%0d want=1", ec[0]); end
    repeat (2) @(posedge clk); #1;
    total++; if (pulses[0] - p !== 1) begin bad++; $display("FAIL stall_pulses got=%0d want=1", pulses[0] - p); end
  endtask

  task automatic test_abort();
    int p;
    int a;
    bq_t pa;
    bq_t pb;
    p = pulses[0];
    a = aborts[0];
    pa = {};
    pb = {};
    for (int i = 0; i < 20; i++) pa.push_back(8'(i + 8'h40));
    for (int i = 0; i < 30; i++) pb.push_back(8'(i * 3));
    send_frame(0, pa, 1'b1, 1'b0, 0);
    send_frame(0, make_frame(pb), 1'b1, 1'b1, 0);
    total++; if (rv[0] !== 1'b1) begin bad++; $display("FAIL abort_new_rv got=%b want=1", rv[0]); end
    total++; if (fa[0] !== 1'b0) begin bad++; $display("FAIL abort_new_fa got=%b want=0", fa[0]); end
    total++; if (fe[0] !== 1'b0) begin bad++; $display("FAIL abort_new_fe got=%b want=0", fe[0]); end
    total++; if (ec[0] !== 16'd2) begin bad++; $display("FAIL abort_ec got=%0d want=2", ec[0]); end
    @(posedge clk); #1;
    total++; if (pulses[0] - p !== 2) begin bad++; $display("FAIL abort_pulses got=%0d want=2", pulses[0] - p); end
    total++; if (aborts[0] - a !== 1) begin bad++; $display("FAIL abort_flagged got=%0d want=1", aborts[0] - a); end
  endtask

  task automatic test_back_to_back();
    int p;
    bq_t pc;
    p = pulses[0];
    pc = {};
    for (int i = 0; i < 12; i++) pc.push_back(8'(8'hF0 - i));
    send_frame(0, make_frame(pc), 1'b1, 1'b1, 0);
    total++; if (rv[0] !== 1'b1) begin bad++; $display("FAIL b2b_first_rv got=%b want=1", rv[0]); end
    total++; if (fe[0] !== 1'b0) begin bad++; $display("FAIL b2b_first_fe got=%b want=0", fe[0]); end
    send_frame(0, check_frame(), 1'b1, 1'b1, 0);
    total++; if (rv[0] !== 1'b1) begin bad++; $display("FAIL b2b_second_rv got=%b want=1", rv[0]); end
    total++; if (fe[0] !== 1'b0) begin bad++; $display("FAIL b2b_second_fe got=%b want=0", fe[0]); end
    total++; if (ec[0] !== 16'd2) begin bad++; $display("FAIL b2b_ec got=%0d want=2", ec[0]); end
    @(posedge clk); #1;
    total++; if (pulses[0] - p !== 2) begin bad++; $display("FAIL b2b_pulses got=%0d want=2", pulses[0] - p); end
  endtask

  task automatic test_eof_idle();
    int p;
    p = pulses[0];
    dv[0] = 1'b1; eof[0] = 1'b1; din[0] = 8'h55;
    @(posedge clk); #1;
    dv[0] = 1'b0; eof[0] = 1'b0;
    repeat (6) @(posedge clk); #1;
    total++; if (pulses[0] - p !== 0) begin bad++; $display("FAIL eof_idle_pulses got=%0d want=0", pulses[0] - p); end
    send_frame(0, check_frame(), 1'b1, 1'b1, 0);
    total++; if (fe[0] !== 1'b0) begin bad++; $display("FAIL eof_idle_next_fe got=%b want=0", fe[0]); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    bq_t f;
    logic [15:0] want;
    f = check_frame();
    f[4] = 8'h3D;
    for (int n = 1; n <= 5; n++) begin
      send_frame(5, f, 1'b1, 1'b1, 0);
      want = (n > 3) ? 16'd3 : 16'(n);
      total++; if (ec[5] !== want) begin bad++; $display("FAIL sat_ec[%0d] got=%0d want=%0d", n, ec[5], want); end
      total++; if (fe[5] !== 1'b1) begin bad++; $display("FAIL sat_fe[%0d] got=%b want=1", n, fe[5]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int p;
    bq_t f;
    bq_t head;
    bq_t tail;
    f = check_frame();
    head = f[0:4];
    tail = f[5:12];
    send_frame(5, head, 1'b1, 1'b0, 0);
    p = pulses[5];
    reset_n = 1'b0;
    #2;
    total++; if (rv[5] !== 1'b0) begin bad++; $display("FAIL rstmid_rv got=%b want=0", rv[5]); end
    total++; if (fe[5] !== 1'b0) begin bad++; $display("FAIL rstmid_fe got=%b want=0", fe[5]); end
    total++; if (re[5] !== 1'b0) begin bad++; $display("FAIL rstmid_re got=%b want=0", re[5]); end
    total++; if (fa[5] !== 1'b0) begin bad++; $display("FAIL rstmid_fa got=%b want=0", fa[5]); end
    total++; if (ec[5] !== 16'd0) begin bad++; $display("FAIL rstmid_ec got=%0d want=0", ec[5]); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    send_frame(5, tail, 1'b0, 1'b1, 0);
    repeat (3) @(posedge clk); #1;
    total++; if (pulses[5] - p !== 0) begin bad++; $display("FAIL rstmid_pulses got=%0d want=0", pulses[5] - p); end
    total++; if (ec[5] !== 16'd0) begin bad++; $display("FAIL rstmid_ec_after got=%0d want=0", ec[5]); end
  endtask

  initial begin
    for (int k = 0; k < 6; k++) begin
      dv[k] = 1'b0; sof[k] = 1'b0; eof[k] = 1'b0; din[k] = 8'd0;
    end
    #2;
    test_reset();
    test_check_value();
    test_corrupt();
    test_runt();
    test_stall();
    test_abort();
    test_back_to_back();
    test_eof_idle();
    test_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
